logic_nbit_unit: RTL
====================

Name: logic_nbit_unit

Overview:
- Parametrised, registered bitwise logic unit; next generation of the fixed 16-bit OR chip.
- Selectable operation (AND/OR/XOR/NAND/NOR/XNOR/NOT/PASS) at any width, with a valid/ready handshake, one-cycle latency and an optional accumulate mode that folds successive operands into an internal register.
- Sits between operand sources and downstream chips; used standalone or as the logic slice of a future ALU.

Parameters:
- WIDTH, 16, data width in bits (>=1).
- ACC_EN, 1, 1 = accumulate mode implemented; 0 = acc/acc_clr ignored, accumulator absent.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand/op bundle valid.
- in_ready  output  1  unit can accept this cycle.
- op  input  3  operation select (encoding below).
- acc  input  1  1 = second operand is the accumulator, not b.
- acc_clr  input  1  synchronous accumulator clear.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out  output  WIDTH  registered result.
- zero  output  1  registered: out == 0.
- ones  output  1  registered: out == all ones.

Behaviour:
- Reset (rst_n low, asynchronous, any cycle): out_valid=0, out=0, zero=0, ones=0, accumulator=0. The cycle in flight is lost; nothing is emitted after release until a new accept.
- op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT a (operand B unused), 7 PASS a.
- Operand B: b when acc=0 or ACC_EN=0; accumulator value when acc=1 and ACC_EN=1.
- Accept: in_valid && in_ready at a rising edge. in_ready = !out_valid || out_ready, combinational, no dependence on in_valid.
- Latency: 1 cycle. At the accepting edge, out gets op(a, B); zero and ones are computed from that same result; out_valid goes to 1.
- Hold: while out_valid && !out_ready, out, zero, ones and out_valid are stable and no input is accepted.
- Drain: out_ready && out_valid with no accept in the same cycle -> out_valid goes to 0 next edge; out keeps its last value.
- Simultaneous drain and accept: the new result replaces the old one, out_valid stays 1. Full throughput is one result per cycle.
- Accumulator update: on an accepted transaction with acc=1, accumulator gets the result.
  - An accepted transaction with acc=0 leaves the accumulator unchanged.
- acc_clr without an accept: accumulator becomes 0 at the next edge.
- acc_clr with an accepted acc=1 transaction: operand B is taken as 0 for that operation, and the accumulator gets the result (clear-then-apply).
- acc_clr with an accepted acc=0 transaction: accumulator becomes 0, and the result uses b.
- acc_clr is honoured regardless of in_ready.
- ACC_EN=0: acc and acc_clr are don't-care; no accumulator flops are generated.
- All results are exactly WIDTH bits; NOT/NAND/NOR/XNOR invert across the full width only.
- WIDTH=1: zero and ones are complementary whenever out_valid=1.

Test Plan:
- Reset/basic: rst_n low then high; a=16'h0000, b=16'hFFFF, op=1, out_ready=1 -> next cycle out=16'hFFFF, out_valid=1, ones=1, zero=0.
- Op sweep: a=16'hA38C, b=16'hC707, ops 0..7 back-to-back -> out = 8304, E78F, 648B, 7CFB, 1870, 9B74, 5C73, A38C, one per cycle, out_valid held 1 throughout.
- Accumulate:
  - acc_clr pulse, then OR with acc=1 on a=000F, 00F0, 0F00 -> out = 000F, 00FF, 0FFF.
  - Then AND with acc=1 on a=0FF0 -> 0FF0.
  - Then acc_clr together with XOR acc=1 on a=1234 -> 1234.
- Backpressure: out_ready=0, in_valid=1 with a=0001 then a=0002 (op=7) -> first accepted; in_ready drops; out=0001 held 3 cycles. Raise out_ready -> out=0002 next cycle, then out_valid=0 after drain.
- Reset mid-operation: out_valid=1 and accumulator=0FFF, out_ready=0; pulse rst_n low between edges -> out_valid, out and accumulator read 0 immediately. First acc OR after release with a=0001 -> 0001.
- Width/param: WIDTH=8, ACC_EN=0; op=4 on a=8'h00, b=8'h00 with acc=1 -> out=8'hFF, ones=1 (acc ignored, b used).

Source files
------------

// File: rtl/logic_nbit_unit.sv
// Registered N-bit bitwise logic unit with valid/ready handshake
// and an optional accumulator that can stand in for operand B.
module logic_nbit_unit #(
  parameter int WIDTH  = 16,
  parameter int ACC_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             ones
);

  logic             accept;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  generate
    if (ACC_EN != 0) begin : g_acc
      logic [WIDTH-1:0] acc_q;

      // clear-then-apply: a pending clear zeroes B for this op
      assign opb = acc ? (acc_clr ? '0 : acc_q) : b;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_q <= '0;
        end else if (accept && acc) begin
          acc_q <= res;
        end else if (acc_clr) begin
          acc_q <= '0;
        end
      end
    end else begin : g_noacc
      logic unused_acc;
      assign unused_acc = acc ^ acc_clr;
      assign opb        = b;
    end
  endgenerate

  always_comb begin
    res = '0;
    unique case (op)
      3'd0: res = a & opb;
      3'd1: res = a | opb;
      3'd2: res = a ^ opb;
      3'd3: res = ~(a & opb);
      3'd4: res = ~(a | opb);
      3'd5: res = ~(a ^ opb);
      3'd6: res = ~a;
      3'd7: res = a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      zero      <= 1'b0;
      ones      <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out       <= res;
      zero      <= (res == '0);
      ones      <= (res == '1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
